// File: rtl/data_lsu.sv
// data_lsu: one-at-a-time LD/ST/SWAP/FADD initiator for the data memory port; LSU_BOUNDS_CHECK_EN adds an upper-address error check.
// Latency: response 2 cycles after accept for LD/ST, 3 for SWAP/FADD; resp_ready low stalls in RESP with memory untouched.
module data_lsu #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_writ_data,
  output logic              mem_writ_en,
  input  logic [DATA_W-1:0] mem_rea_data
);

  localparam logic [1:0] OP_LD   = 2'b00;
  localparam logic [1:0] OP_ST   = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_FADD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  if (MEM_AW > ADDR_W) begin : g_bad_cfg
    $error("data_lsu: MEM_AW must not exceed ADDR_W");
  end

  state_t            state, state_nxt;
  req_t              req_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] wd_hold_q;
  logic [DATA_W-1:0] wr_val;
  logic              accept;
  logic              oob;

  assign accept = req_valid && req_ready;

`ifdef LSU_BOUNDS_CHECK_EN
  logic err_q;

  assign oob = |req_q.addr[ADDR_W-1:MEM_AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state == S_ACCESS && oob) begin
      err_q <= 1'b1;
    end
  end

  assign resp_err = err_q;
`else
  // Upper address bits pass through; memory ignores them and aliases.
  assign oob      = 1'b0;
  assign resp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (oob || req_q.op == OP_LD || req_q.op == OP_ST) begin
          state_nxt = S_RESP;
        end else begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: state_nxt = S_RESP;
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; req_ready is gated by rst_n so it reads 0 throughout reset
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_writ_en = 1'b0;
    case (state)
      S_IDLE:   req_ready   = rst_n;
      S_ACCESS: mem_writ_en = (req_q.op == OP_ST) && !oob;
      S_WRITE:  mem_writ_en = 1'b1;
      S_RESP:   resp_valid  = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    wr_val = req_q.wdata;
    if (state == S_WRITE && req_q.op == OP_FADD) begin
      wr_val = rdata_q + req_q.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      rdata_q   <= '0;
      wd_hold_q <= '0;
    end else begin
      if (accept) begin
        req_q.op    <= req_op;
        req_q.addr  <= req_base + req_offset;
        req_q.wdata <= req_wdata;
      end
      if (state == S_ACCESS) begin
        if (oob || req_q.op == OP_ST) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= mem_rea_data;
        end
      end
      if (mem_writ_en) begin
        wd_hold_q <= wr_val;
      end
    end
  end

  // Address and write data hold their last driven value between operations
  assign mem_access_addr = req_q.addr;
  assign mem_writ_data   = mem_writ_en ? wr_val : wd_hold_q;
  assign resp_data       = rdata_q;

endmodule

// File: doc/data_lsu.md
# data_lsu

Load/store initiator for the 16-bit data memory port of the MIPS datapath. Accepts one memory operation at a time from the execute stage over a valid/ready request channel and computes the effective address as base + offset. Drives the data memory's shared address, write-data and write-enable lines, and returns load data over a valid/ready response channel. Also supports two read-modify-write operations, swap and fetch-add, so software gets atomic updates without extra pipeline logic.

## Interface
- ADDR_W, 16, effective address width
- DATA_W, 16, data word width
- MEM_AW, 8, implemented memory index width; used only by the bounds check
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  2  operation: 00 LD, 01 ST, 10 SWAP, 11 FADD
- req_base  in  ADDR_W  base address
- req_offset  in  ADDR_W  offset, added to req_base
- req_wdata  in  DATA_W  store, swap or addend data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_data  out  DATA_W  load data, or old value for SWAP/FADD; 0 for ST
- resp_err  out  1  out-of-range access (see Configuration)
- mem_access_addr  out  ADDR_W  to data memory address
- mem_writ_data  out  DATA_W  to data memory write data
- mem_writ_en  out  1  to data memory write enable
- mem_rea_data  in  DATA_W  from data memory; combinational read of mem_access_addr

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid&&req_ready, latch the following, then go to ACCESS:
    - op;
    - addr_q = (req_base + req_offset) mod 2^ADDR_W, with the carry discarded;
    - wdata_q.
- **ACCESS**
  - mem_access_addr=addr_q.
  - LD: rdata_q <= mem_rea_data; go to RESP.
  - ST: mem_writ_en=1 and mem_writ_data=wdata_q for this cycle; rdata_q <= 0; go to RESP.
  - SWAP and FADD: rdata_q <= mem_rea_data; go to WRITE.
- **WRITE**
  - mem_access_addr=addr_q and mem_writ_en=1.
  - mem_writ_data=wdata_q for SWAP.
  - mem_writ_data=(rdata_q + wdata_q) mod 2^DATA_W for FADD.
  - Go to RESP.
- **RESP**
  - resp_valid=1, resp_data=rdata_q.
  - Hold until resp_ready=1, then go to IDLE.
- Outside IDLE: req_ready=0. Exactly one operation is outstanding at a time.
- Outside ACCESS(ST) and WRITE: mem_writ_en=0.
- mem_access_addr and mem_writ_data hold their last value while idle.
- resp_data and resp_err stay stable from resp_valid rising until the handshake completes.
- Reset, including mid-operation:
  - asynchronously forces IDLE;
  - mem_writ_en drops immediately;
  - any pending response is discarded.

## Timing
- Values with rst_n low:
  - req_ready=0, resp_valid=0, resp_data=0, resp_err=0;
  - mem_access_addr=0, mem_writ_data=0, mem_writ_en=0.
- First cycle after rst_n deasserts: IDLE with req_ready=1.
- Accept at edge T. Let D be the cycle count from the accepting edge to resp_valid.
  - LD and ST: resp_valid from cycle T+2, so D=2.
  - SWAP and FADD: resp_valid from cycle T+3, so D=3.
- Store write commit:
  - ST: committed at the edge ending the ACCESS cycle.
  - RMW: committed at the edge ending WRITE.
  - The written value is visible to a following LD's ACCESS cycle.
- Throughput with resp_ready tied high:
  - one LD/ST per 3 cycles;
  - one RMW per 4 cycles.
  - The extra cycle is IDLE.
- Back-pressure: each cycle resp_ready=0 in RESP adds one cycle. Memory is not touched while stalled.

## Configuration
- LSU_BOUNDS_CHECK_EN defined:
  - In ACCESS, if addr_q[ADDR_W-1:MEM_AW] != 0:
    - no write is issued for any op;
    - rdata_q <= 0 and resp_err <= 1;
    - go directly to RESP.
  - resp_err clears when the next request is accepted.
- LSU_BOUNDS_CHECK_EN undefined:
  - The full address is driven and the upper bits are ignored by memory, so access aliases modulo 2^MEM_AW.
  - resp_err is tied to 0.

## Test plan
- Reset mid-RMW:
  - Stimulus: assert rst_n=0 during WRITE of FADD.
  - Required: mem_writ_en falls immediately; all outputs reach their reset values.
  - After release: the memory word is unchanged and req_ready=1 one cycle later.
- Store then load:
  - Stimulus: ST base=0x0010 off=0x0005 data=0xBEEF, then LD base=0x0015 off=0.
  - Required: write at 0x0015; LD resp_data=0xBEEF with D=2; resp_err=0.
- FADD wrap:
  - Stimulus: memory[0x20]=0xFFFE; FADD addr 0x20 data=0x0003.
  - Required: resp_data=0xFFFE; memory[0x20]=0x0001; D=3.
- Address wrap and bounds:
  - Stimulus: base=0xFFFF off=0x0002, giving effective address 0x0001.
  - Required: access to 0x0001, resp_err=0.
  - Further stimulus: base=0x0100 off=0 ST.
    - With LSU_BOUNDS_CHECK_EN: resp_err=1, no mem_writ_en pulse.
    - Without it: a write to 0x0000 occurs.
- Back-pressure:
  - Stimulus: LD with resp_ready held 0 for 5 cycles and req_valid held 1.
  - Required: resp_valid and resp_data stable; req_ready=0; no second accept until the handshake completes.
- SWAP:
  - Stimulus: memory[0x40]=0x1234; SWAP data=0xAAAA.
  - Required: resp_data=0x1234; memory[0x40]=0xAAAA.
